// File: rtl/mul_unit_ctrl_if.sv
// Request, response and multiplier-side signals of mul_unit_ctrl.
// slave: the controller's view. master: the execute stage plus multiplier.
interface mul_unit_ctrl_if;
  // Execute-stage request
  logic        s_valid_i;
  logic        s_ready_o;
  logic [2:0]  s_funct3_i;
  logic [31:0] s_rs1_i;
  logic [31:0] s_rs2_i;
  logic        s_flush_i;
  // Result handshake
  logic        s_valid_o;
  logic        s_ready_i;
  logic [31:0] s_rd_o;
  logic        s_err_o;
  // Multiplier datapath
  logic        m_compute_o;
  logic        m_cancel_o;
  logic [31:0] m_multiplicand_o;
  logic [31:0] m_multiplier_o;
  logic        m_busy_i;
  logic [63:0] m_result_i;

  modport slave (
    input  s_valid_i, s_funct3_i, s_rs1_i, s_rs2_i, s_flush_i, s_ready_i,
    input  m_busy_i, m_result_i,
    output s_ready_o, s_valid_o, s_rd_o, s_err_o,
    output m_compute_o, m_cancel_o, m_multiplicand_o, m_multiplier_o
  );

  modport master (
    output s_valid_i, s_funct3_i, s_rs1_i, s_rs2_i, s_flush_i, s_ready_i,
    output m_busy_i, m_result_i,
    input  s_ready_o, s_valid_o, s_rd_o, s_err_o,
    input  m_compute_o, m_cancel_o, m_multiplicand_o, m_multiplier_o
  );
endinterface

// File: rtl/mul_unit_ctrl.sv
// RV32M multiply controller: turns signed operands into magnitudes, drives the
// shift-add multiplier, sign-corrects the unsigned product and returns the low
// or high word. Includes a zero-operand bypass, flush and a RUN watchdog.
module mul_unit_ctrl #(
  parameter bit          FAST_ZERO      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input logic           s_clk_i,
  input logic           s_resetn_i,
  mul_unit_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mag_a_q, mag_a_d;
  logic [31:0]       mag_b_q, mag_b_d;
  logic              neg_r_q, neg_r_d;
  logic              hi_q, hi_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              accept;
  logic              sign_a, sign_b, neg_a, neg_b;
  logic [63:0]       product;

  assign bus.s_ready_o        = (state_q == StIdle) & ~bus.m_busy_i & ~bus.s_flush_i;
  assign accept               = bus.s_valid_i & bus.s_ready_o;
  assign bus.s_valid_o        = (state_q == StDone);
  assign bus.s_rd_o           = rd_q;
  assign bus.s_err_o          = err_q;
  assign bus.m_multiplicand_o = mag_a_q;
  assign bus.m_multiplier_o   = mag_b_q;

  // Operand sign decode for the incoming request
  always_comb begin
    sign_a  = (bus.s_funct3_i == 3'b001) | (bus.s_funct3_i == 3'b010);
    sign_b  = (bus.s_funct3_i == 3'b001);
    neg_a   = sign_a & bus.s_rs1_i[31];
    neg_b   = sign_b & bus.s_rs2_i[31];
    // Sign-corrected product; only meaningful once the multiplier has finished
    product = neg_r_q ? (64'd0 - bus.m_result_i) : bus.m_result_i;
  end

  // Next-state, register updates and decoded multiplier controls
  always_comb begin
    state_d         = state_q;
    mag_a_d         = mag_a_q;
    mag_b_d         = mag_b_q;
    neg_r_d         = neg_r_q;
    hi_d            = hi_q;
    rd_d            = rd_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    bus.m_compute_o = 1'b0;
    bus.m_cancel_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mag_a_d = neg_a ? (32'd0 - bus.s_rs1_i) : bus.s_rs1_i;
          mag_b_d = neg_b ? (32'd0 - bus.s_rs2_i) : bus.s_rs2_i;
          neg_r_d = neg_a ^ neg_b;
          hi_d    = (bus.s_funct3_i != 3'b000);
          if (bus.s_funct3_i[2]) begin
            rd_d    = 32'd0;
            err_d   = 1'b1;
            state_d = StDone;
          end else if (FAST_ZERO && ((bus.s_rs1_i == 32'd0) || (bus.s_rs2_i == 32'd0))) begin
            rd_d    = 32'd0;
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.s_flush_i) begin
          state_d = StIdle;
        end else begin
          bus.m_compute_o = 1'b1;
          cnt_d           = '0;
          state_d         = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.s_flush_i) begin
          // Only cancel if the multiplier is still working; a finished result is just dropped
          bus.m_cancel_o = bus.m_busy_i;
          state_d        = StIdle;
        end else if (!bus.m_busy_i) begin
          rd_d    = hi_q ? product[63:32] : product[31:0];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == TimeoutVal) begin
          bus.m_cancel_o = 1'b1;
          rd_d           = 32'd0;
          err_d          = 1'b1;
          state_d        = StDone;
        end
      end
      StDone: begin
        if (bus.s_flush_i || bus.s_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state_q <= StIdle;
      mag_a_q <= 32'd0;
      mag_b_q <= 32'd0;
      neg_r_q <= 1'b0;
      hi_q    <= 1'b0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Bench for mul_unit_ctrl: multiplier stub, directed table, random ops against
// a signed-arithmetic reference, and flush/reset/backpressure/timeout sequences.
module tb_mul_unit_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mul_unit_ctrl_if bus ();

  mul_unit_ctrl #(
    .FAST_ZERO      (1'b1),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .s_clk_i    (clk),
    .s_resetn_i (resetn),
    .bus        (bus)
  );

  // Multiplier stub: busy for 33 cycles after compute, optionally stuck busy
  int          busy_cnt;
  logic [63:0] stub_res;
  logic        stuck;
  assign bus.m_busy_i   = (busy_cnt != 0);
  assign bus.m_result_i = stub_res;

  always @(posedge clk) begin
    if (!resetn) begin
      busy_cnt <= 0;
      stub_res <= 64'd0;
    end else if (bus.m_cancel_o) begin
      busy_cnt <= 0;
    end else if (bus.m_compute_o) begin
      busy_cnt <= 33;
      stub_res <= {32'd0, bus.m_multiplicand_o} * {32'd0, bus.m_multiplier_o};
    end else if (busy_cnt != 0 && !stuck) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Compute monitor
  int          compute_cnt;
  int          compute_while_busy;
  logic [31:0] last_ma, last_mb;
  always @(posedge clk) begin
    if (bus.m_compute_o) begin
      compute_cnt <= compute_cnt + 1;
      last_ma     <= bus.m_multiplicand_o;
      last_mb     <= bus.m_multiplier_o;
      if (bus.m_busy_i) compute_while_busy <= compute_while_busy + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level reference: signed/unsigned 64-bit product, then word select
  function automatic logic [32:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    if (f3[2]) return {1'b1, 32'd0};
    ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return {1'b0, (f3 == 3'b000) ? p[31:0] : p[63:32]};
  endfunction

  // Present one request; returns in the cycle after accept
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!bus.s_ready_o && w < 100) begin
      tick();
      w++;
    end
    check("ready_before_issue", bus.s_ready_o, 1);
    bus.s_valid_i  = 1'b1;
    bus.s_funct3_i = f3;
    bus.s_rs1_i    = a;
    bus.s_rs2_i    = b;
    tick();
    bus.s_valid_i = 1'b0;
  endtask

  // Count cycles from accept (cycle 0) until s_valid_o
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.s_valid_o && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack();
    bus.s_ready_i = 1'b1;
    tick();
    bus.s_ready_i = 1'b0;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          computes;
    logic [31:0] ma, mb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, c0;
    logic [32:0] exp;
    logic [31:0] corner[5];

    compute_cnt = 0;
    compute_while_busy = 0;
    last_ma = 0;
    last_mb = 0;
    stuck = 1'b0;
    bus.s_valid_i = 0; bus.s_funct3_i = 0; bus.s_rs1_i = 0; bus.s_rs2_i = 0;
    bus.s_flush_i = 0; bus.s_ready_i = 0;
    resetn = 1'b0;
    repeat (3) tick();

    check("rst_valid",   bus.s_valid_o, 0);
    check("rst_rd",      bus.s_rd_o, 0);
    check("rst_err",     bus.s_err_o, 0);
    check("rst_compute", bus.m_compute_o, 0);
    check("rst_cancel",  bus.m_cancel_o, 0);
    resetn = 1'b1;
    tick();
    check("rst_ready", bus.s_ready_o, 1);

    vecs.push_back('{"mul_7x6",      3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 36, 1, 32'd7, 32'd6});
    vecs.push_back('{"mulh_m1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 36, 1,
                     32'd1, 32'd1});
    vecs.push_back('{"mulhu_m1",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 36,
                     1, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{"mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 36,
                     1, 32'd1, 32'hFFFFFFFF});
    vecs.push_back('{"mul_m1",       3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 36, 1,
                     32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{"mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 36,
                     1, 32'h80000000, 32'h80000000});
    vecs.push_back('{"mulhsu_min",   3'b010, 32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0, 36, 1,
                     32'h80000000, 32'd2});
    vecs.push_back('{"mul_zero",     3'b000, 32'd0, 32'd5, 32'd0, 1'b0, 1, 0, 32'd0, 32'd0});
    vecs.push_back('{"illegal_100",  3'b100, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0});
    vecs.push_back('{"illegal_zero", 3'b111, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0});

    foreach (vecs[i]) begin
      c0 = compute_cnt;
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done(lat);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_rd"},  bus.s_rd_o, vecs[i].rd);
      check({vecs[i].name, "_err"}, bus.s_err_o, vecs[i].err);
      check({vecs[i].name, "_ncomp"}, compute_cnt - c0, vecs[i].computes);
      if (vecs[i].computes != 0) begin
        check({vecs[i].name, "_ma"}, last_ma, vecs[i].ma);
        check({vecs[i].name, "_mb"}, last_mb, vecs[i].mb);
      end
      ack();
      check({vecs[i].name, "_vdrop"}, bus.s_valid_o, 0);
    end

    // Random operations against the reference model
    corner = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      exp = ref_model(f3, a, b);
      issue(f3, a, b);
      wait_done(lat);
      check("rand_lat", lat, (f3[2] || a == 0 || b == 0) ? 1 : 36);
      check("rand_rd",  bus.s_rd_o, exp[31:0]);
      check("rand_err", bus.s_err_o, exp[32]);
      repeat ($urandom_range(0, 2)) tick();
      ack();
    end

    // Flush in the 10th RUN cycle (cycle 11 after accept)
    issue(3'b000, 32'd9, 32'd9);
    repeat (10) tick();
    bus.s_flush_i = 1'b1;
    #1;
    check("flush_run_cancel", bus.m_cancel_o, 1);
    tick();
    bus.s_flush_i = 1'b0;
    #1;
    check("flush_run_cancel_pulse", bus.m_cancel_o, 0);
    check("flush_run_busy", bus.m_busy_i, 0);
    check("flush_run_ready", bus.s_ready_o, 1);
    begin
      int vcnt = 0;
      repeat (40) begin
        if (bus.s_valid_o) vcnt++;
        tick();
      end
      check("flush_run_no_valid", vcnt, 0);
    end

    // Flush in the ISSUE cycle
    c0 = compute_cnt;
    issue(3'b000, 32'd9, 32'd9);
    bus.s_flush_i = 1'b1;
    #1;
    check("flush_issue_compute", bus.m_compute_o, 0);
    tick();
    bus.s_flush_i = 1'b0;
    #1;
    check("flush_issue_busy", bus.m_busy_i, 0);
    check("flush_issue_ready", bus.s_ready_o, 1);
    check("flush_issue_ncomp", compute_cnt - c0, 0);

    // Backpressure: result held for 5 cycles
    issue(3'b000, 32'd3, 32'd5);
    wait_done(lat);
    check("hold_lat", lat, 36);
    repeat (5) begin
      check("hold_rd", bus.s_rd_o, 32'd15);
      check("hold_valid", bus.s_valid_o, 1);
      check("hold_ready_o", bus.s_ready_o, 0);
      tick();
    end
    ack();
    check("hold_vdrop", bus.s_valid_o, 0);

    // Reset in the middle of RUN
    issue(3'b000, 32'd11, 32'd13);
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    check("mid_rst_valid",   bus.s_valid_o, 0);
    check("mid_rst_rd",      bus.s_rd_o, 0);
    check("mid_rst_err",     bus.s_err_o, 0);
    check("mid_rst_compute", bus.m_compute_o, 0);
    check("mid_rst_cancel",  bus.m_cancel_o, 0);
    check("mid_rst_ready",   bus.s_ready_o, 1);
    resetn = 1'b1;
    tick();

    // Watchdog: busy stuck; counter 0 in cycle 2, reaches 40 in cycle 42
    stuck = 1'b1;
    issue(3'b001, 32'd3, 32'd3);
    lat = 1;
    while (!bus.m_cancel_o && lat < 200) begin
      tick();
      lat++;
    end
    check("timeout_cycle", lat, 42);
    tick();
    check("timeout_cancel_pulse", bus.m_cancel_o, 0);
    check("timeout_valid", bus.s_valid_o, 1);
    check("timeout_err", bus.s_err_o, 1);
    check("timeout_rd", bus.s_rd_o, 0);
    stuck = 1'b0;
    ack();
    check("timeout_ready", bus.s_ready_o, 1);

    check("compute_while_busy", compute_while_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_unit_ctrl.md
Name: mul_unit_ctrl

Overview:
- Controller between the execute stage and the 32-cycle shift-add `multiplier` datapath; implements RV32M MUL, MULH, MULHSU and MULHU.
- Accepts one operation per valid/ready handshake and converts signed operands to magnitudes.
- Sequences the multiplier's compute/cancel/busy protocol, applies the sign correction to the 64-bit product and selects the low or high word.
- Returns the result over a valid/ready handshake.
- Provides a zero-operand fast path, a pipeline flush and a watchdog timeout.

Parameters:
- FAST_ZERO, 1: when 1, an operand equal to zero bypasses the multiplier and the result is 0.
- TIMEOUT_CYCLES, 40: maximum number of cycles in RUN before the operation is aborted with an error.

Ports:
- s_clk_i  input  1  clock
- s_resetn_i  input  1  reset; synchronous, active-low
- s_valid_i  input  1  request valid
- s_ready_o  output  1  controller can accept a request
- s_funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx illegal
- s_rs1_i  input  32  operand A
- s_rs2_i  input  32  operand B
- s_flush_i  input  1  kill the in-flight operation
- s_valid_o  output  1  result valid
- s_ready_i  input  1  consumer accepts the result
- s_rd_o  output  32  result word
- s_err_o  output  1  qualifies s_rd_o: illegal funct3 or timeout
- m_compute_o  output  1  to multiplier s_compute_i
- m_cancel_o  output  1  to multiplier s_cancel_i
- m_multiplicand_o  output  32  magnitude of A
- m_multiplier_o  output  32  magnitude of B
- m_busy_i  input  1  from multiplier s_busy_o
- m_result_i  input  64  from multiplier s_result_o (unsigned product)

Behaviour:
- Reset (s_resetn_i low at a clock edge):
  - state goes to IDLE.
  - s_valid_o, s_err_o, s_rd_o, the operand registers and the timeout counter all go to 0.
  - m_compute_o and m_cancel_o are decoded from state and are 0 in IDLE.
- s_ready_o = (state==IDLE) & ~m_busy_i & ~s_flush_i.
- Accept = s_valid_i & s_ready_o. At accept, register:
  - signA = funct3 in {001, 010}; signB = funct3==001.
  - negA = signA & rs1[31]; negB = signB & rs2[31].
  - magA = negA ? -rs1 : rs1 (32-bit two's complement; 0x80000000 stays 0x80000000); magB likewise.
  - negR = negA ^ negB; hi = funct3!=000.
- States and transitions:
  - IDLE -> DONE on accept with funct3[2]=1: s_rd_o=0, s_err_o=1.
  - IDLE -> DONE on accept with FAST_ZERO=1 and (rs1==0 or rs2==0): s_rd_o=0, s_err_o=0. m_compute_o is never asserted.
  - IDLE -> ISSUE on any other accept.
  - ISSUE: m_compute_o=1, driving the registered magA/magB. Always -> RUN; the timeout counter clears to 0.
  - RUN: counter increments every cycle. While in RUN, if m_busy_i==0 (multiplier finished; in RUN this only happens once its result is ready):
    - P = negR ? -m_result_i : m_result_i (64-bit).
    - s_rd_o = hi ? P[63:32] : P[31:0]; s_err_o=0; -> DONE.
  - RUN timeout: if the counter reaches TIMEOUT_CYCLES, m_cancel_o=1 that cycle, s_rd_o=0, s_err_o=1, -> DONE.
  - DONE: s_valid_o=1. s_rd_o and s_err_o are held stable until s_ready_i=1, then -> IDLE (s_valid_o drops next cycle).
- Latency:
  - Normal path: accept in cycle 0, ISSUE in cycle 1, m_busy_i high in cycles 2..34, RUN sees busy low in cycle 35, s_valid_o=1 in cycle 36.
  - Fast and illegal paths: s_valid_o=1 in cycle 1.
- Flush:
  - In ISSUE: m_compute_o is suppressed (0) and the state goes to IDLE.
  - In RUN with m_busy_i=1: m_cancel_o=1 for exactly that cycle, -> IDLE, no result.
  - In RUN in the same cycle that busy falls: the result is dropped, -> IDLE.
  - In DONE: s_valid_o drops next cycle, -> IDLE.
  - In IDLE: blocks accept for that cycle only.
  - Flush has priority over completion and timeout.
- Ordering: m_compute_o is asserted only in ISSUE, and ISSUE is reachable only when m_busy_i was 0 at accept, so the multiplier never receives compute while busy.
- Reset mid-operation: the controller returns to IDLE. m_cancel_o is not driven; the multiplier is reset by the same s_resetn_i.

Test Plan:
1. MUL rs1=7, rs2=6 -> m_compute_o for 1 cycle with 7/6; s_valid_o in cycle 36 after accept; s_rd_o=42, s_err_o=0.
2. rs1=rs2=0xFFFFFFFF -> MULH: s_rd_o=0x00000000; MULHU: 0xFFFFFFFE; MULHSU: 0xFFFFFFFF; MUL: 0x00000001.
3. MULH rs1=rs2=0x80000000 -> magnitudes 0x80000000 driven on m_*; s_rd_o=0x40000000. MULHSU rs1=0x80000000, rs2=2 -> 0xFFFFFFFF.
4. MUL rs1=0, rs2=5 -> s_valid_o in cycle 1, s_rd_o=0, m_compute_o never high. funct3=100 -> s_valid_o in cycle 1 with s_err_o=1.
5. Flush in the 10th RUN cycle -> m_cancel_o high for exactly 1 cycle; m_busy_i low next cycle; s_valid_o never asserts; s_ready_o=1 again. Flush in the ISSUE cycle -> m_compute_o=0, no busy.
6. s_ready_i held low for 5 cycles in DONE -> s_rd_o stable and s_ready_o=0 throughout, then one handshake. Reset asserted mid-RUN -> all outputs 0, IDLE. Stub with m_busy_i stuck at 1 -> timeout at 40: m_cancel_o pulse, s_err_o=1.
